// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   APB master that shares a UART's TX path between two byte-stream
//   requesters. For every byte it reads the UART status register, backs off
//   while the TX FIFO is full, then writes the granted requester's byte to
//   the write-data register. Arbitration is round-robin with a bounded burst
//   per owner while the other requester is waiting.
//
//   Optional feature macro: UART_TX_ARBITER_RX_EN
//     When defined, the block also drains the UART RX FIFO. It polls status
//     while idle, and after any status read showing RX not empty it reads
//     0x8 and presents the byte on rx_data/rx_valid until rx_ready.
//     RX reads take priority over TX writes.
//
// Ports
//   PCLK, PRESET            clock, asynchronous active-high reset
//   reqN_data/valid/ready   requester byte streams; ready is a one-cycle
//                           pulse in the cycle the byte is written
//   PADDR..PREADY           APB master interface (0x0 status, 0x4 TX data,
//                           0x8 RX data); PRDATA[3:0] = {rx_full, tx_empty,
//                           tx_full, rx_empty}
//   grant                   one-hot owner of the current transfer
//   busy                    high whenever the FSM is not idle
//   rx_data/valid/ready     captured RX byte (only with the macro)
//
// state       | meaning
// ------------+--------------------------------------------------------
// S_IDLE      | no transfer; arbitrate (or idle-poll with RX enabled)
// S_RD_SETUP  | APB setup phase of a status read at 0x0
// S_RD_ACCESS | APB access phase of the status read, wait for PREADY
// S_WAIT      | TX FIFO full, back off POLL_GAP cycles before re-polling
// S_WR_SETUP  | APB setup phase of the TX data write at 0x4
// S_WR_ACCESS | APB access phase of the write; ready pulse on PREADY
// S_RX_SETUP  | APB setup phase of an RX data read at 0x8 (RX build)
// S_RX_ACCESS | APB access phase of the RX data read (RX build)

module uart_tx_arbiter #(
  parameter int POLL_GAP = 4,
  parameter int BURST    = 4
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [7:0]  req0_data,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req1_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  output logic [3:0]  PADDR,
  output logic [31:0] PWDATA,
  output logic        PWRITE,
  output logic        PSEL,
  output logic        PENABLE,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
`ifdef UART_TX_ARBITER_RX_EN
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
`endif
  output logic [1:0]  grant,
  output logic        busy
);

  localparam int BCW = $clog2(BURST + 1);
  localparam int PGW = $clog2(POLL_GAP + 1);
  localparam logic [BCW-1:0] BURST_MAX = BCW'(BURST);
  localparam logic [BCW-1:0] BURST_ONE = BCW'(1);
  localparam logic [PGW-1:0] GAP_LOAD  = PGW'(POLL_GAP - 1);
  localparam logic [PGW-1:0] GAP_ONE   = PGW'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RD_SETUP  = 3'd1,
    S_RD_ACCESS = 3'd2,
    S_WAIT      = 3'd3,
    S_WR_SETUP  = 3'd4,
    S_WR_ACCESS = 3'd5,
    S_RX_SETUP  = 3'd6,
    S_RX_ACCESS = 3'd7
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic [7:0]      byte_q, byte_d;
  logic            last_q, last_d;
  logic [BCW-1:0]  burst_q, burst_d;
  logic [PGW-1:0]  wait_q, wait_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic            pwrite_q, pwrite_d;
  logic [3:0]      paddr_q, paddr_d;
  logic [31:0]     pwdata_q, pwdata_d;
  logic            pick1;
  logic            served;
  logic            prdata_unused;

`ifdef UART_TX_ARBITER_RX_EN
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            txfull_q, txfull_d;
  logic [PGW-1:0]  idle_q, idle_d;
`endif

  // Only the status flags (and the RX byte, when enabled) are consumed.
  assign prdata_unused = ^PRDATA;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      byte_q     <= '0;
      last_q     <= 1'b0;
      burst_q    <= '0;
      wait_q     <= '0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
`ifdef UART_TX_ARBITER_RX_EN
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      txfull_q   <= 1'b0;
      idle_q     <= GAP_LOAD;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      byte_q     <= byte_d;
      last_q     <= last_d;
      burst_q    <= burst_d;
      wait_q     <= wait_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
`ifdef UART_TX_ARBITER_RX_EN
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      txfull_q   <= txfull_d;
      idle_q     <= idle_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    byte_d     = byte_q;
    last_d     = last_q;
    burst_d    = burst_q;
    wait_d     = wait_q;
    psel_d     = 1'b0;
    penable_d  = 1'b0;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    pick1      = 1'b0;
    served     = 1'b0;
`ifdef UART_TX_ARBITER_RX_EN
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q & ~rx_ready;
    txfull_d   = txfull_q;
    idle_d     = GAP_LOAD;
`endif

    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          // Contention: the last owner keeps the grant until its burst is used up.
          if (req0_valid && req1_valid) pick1 = (burst_q < BURST_MAX) ? last_q : ~last_q;
          else                          pick1 = req1_valid;
          grant_d = pick1 ? 2'b10 : 2'b01;
          byte_d  = pick1 ? req1_data : req0_data;
          state_d = S_RD_SETUP;
        end
`ifdef UART_TX_ARBITER_RX_EN
        else if (!rx_valid_q) begin
          if (idle_q == '0) state_d = S_RD_SETUP;
          else              idle_d  = idle_q - GAP_ONE;
        end
`endif
      end

      S_RD_SETUP: state_d = S_RD_ACCESS;

      S_RD_ACCESS: begin
        if (PREADY) begin
`ifdef UART_TX_ARBITER_RX_EN
          txfull_d = PRDATA[1];
          if (!PRDATA[0] && !rx_valid_q) state_d = S_RX_SETUP;
          else if (grant_q == 2'b00)     state_d = S_IDLE;
          else if (PRDATA[1]) begin
            state_d = S_WAIT;
            wait_d  = GAP_LOAD;
          end else                       state_d = S_WR_SETUP;
`else
          if (PRDATA[1]) begin
            state_d = S_WAIT;
            wait_d  = GAP_LOAD;
          end else begin
            state_d = S_WR_SETUP;
          end
`endif
        end
      end

      S_WAIT: begin
        if (wait_q == '0) state_d = S_RD_SETUP;
        else              wait_d  = wait_q - GAP_ONE;
      end

      S_WR_SETUP: state_d = S_WR_ACCESS;

      S_WR_ACCESS: begin
        if (PREADY) begin
          req0_ready = grant_q[0];
          req1_ready = grant_q[1];
          served     = grant_q[1];
          if (served == last_q) begin
            // Saturate so a lone requester never wraps back into a fresh burst.
            if (burst_q < BURST_MAX) burst_d = burst_q + BURST_ONE;
          end else begin
            last_d  = served;
            burst_d = BURST_ONE;
          end
          grant_d = 2'b00;
          state_d = S_IDLE;
        end
      end

`ifdef UART_TX_ARBITER_RX_EN
      S_RX_SETUP: state_d = S_RX_ACCESS;

      S_RX_ACCESS: begin
        if (PREADY) begin
          rx_data_d  = PRDATA[7:0];
          rx_valid_d = 1'b1;
          // Resume the pending TX byte using the status seen just before.
          if (grant_q == 2'b00) state_d = S_IDLE;
          else if (txfull_q) begin
            state_d = S_WAIT;
            wait_d  = GAP_LOAD;
          end else              state_d = S_WR_SETUP;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase

    // APB outputs are registered from the state being entered, so they are
    // stable for the whole phase and hold address/data between accesses.
    case (state_d)
      S_RD_SETUP: begin
        psel_d   = 1'b1;
        pwrite_d = 1'b0;
        paddr_d  = 4'h0;
      end
      S_RD_ACCESS, S_WR_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      S_WR_SETUP: begin
        psel_d   = 1'b1;
        pwrite_d = 1'b1;
        paddr_d  = 4'h4;
        pwdata_d = {24'h0, byte_q};
      end
`ifdef UART_TX_ARBITER_RX_EN
      S_RX_SETUP: begin
        psel_d   = 1'b1;
        pwrite_d = 1'b0;
        paddr_d  = 4'h8;
      end
      S_RX_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign grant   = grant_q;
  assign busy    = (state_q != S_IDLE);

`ifdef UART_TX_ARBITER_RX_EN
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: APB slave model with a 2-cycle PREADY
// response and a scripted status queue, two requester models fed from byte
// queues, and a scoreboard of expected writes compared against the logged
// APB writes.

module tb_uart_tx_arbiter;
  localparam int POLL_GAP = 3;
  localparam int BURST    = 2;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic [7:0]  req0_data = '0, req1_data = '0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA = 32'h4;
  logic        PREADY;
  logic [1:0]  grant;
  logic        busy;
`ifdef UART_TX_ARBITER_RX_EN
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b1;
`endif

  uart_tx_arbiter #(.POLL_GAP(POLL_GAP), .BURST(BURST)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY),
`ifdef UART_TX_ARBITER_RX_EN
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
`endif
    .grant(grant), .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // APB slave: PREADY on the second access cycle; optional stray PREADY while unselected.
  int          acc_cnt = 0;
  logic        stray = 1'b0;
  logic [31:0] status_q[$];
  assign PREADY = (PSEL && PENABLE && acc_cnt == 1) || (stray && !PSEL);

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
    if (PSEL && PENABLE && PREADY && !PWRITE && PADDR == 4'h0 && status_q.size() > 0)
      void'(status_q.pop_front());
  end

  always @(negedge PCLK) PRDATA = (status_q.size() > 0) ? status_q[0] : 32'h4;

  // Requesters: hold the front byte until the ready pulse is seen.
  logic [7:0] src0_q[$];
  logic [7:0] src1_q[$];
  always @(negedge PCLK) begin
    if (req0_ready && src0_q.size() > 0) void'(src0_q.pop_front());
    if (req1_ready && src1_q.size() > 0) void'(src1_q.pop_front());
    req0_valid = (src0_q.size() > 0);
    req0_data  = req0_valid ? src0_q[0] : 8'h00;
    req1_valid = (src1_q.size() > 0);
    req1_data  = req1_valid ? src1_q[0] : 8'h00;
  end

  typedef struct {
    int          cyc;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        r0;
    logic        r1;
    logic [1:0]  gnt;
  } wr_rec_t;

  typedef struct {
    logic       who;
    logic [7:0] data;
  } exp_t;

  wr_rec_t wr_log[$];
  exp_t    exp_q[$];
  int      rd_done_log[$];
  int      rd_setup_log[$];
  int      rdy_cnt0 = 0, rdy_cnt1 = 0, bad_rd_addr = 0;

  always @(negedge PCLK) begin
    if (PSEL && PENABLE && PREADY) begin
      if (PWRITE) wr_log.push_back('{cyc, PADDR, PWDATA, req0_ready, req1_ready, grant});
      else begin
        rd_done_log.push_back(cyc);
        if (PADDR != 4'h0) bad_rd_addr++;
      end
    end
    if (PSEL && !PENABLE && !PWRITE) rd_setup_log.push_back(cyc);
    if (req0_ready) rdy_cnt0++;
    if (req1_ready) rdy_cnt1++;
  end

  task automatic do_reset();
    PRESET = 1'b1;
    stray  = 1'b0;
    src0_q.delete(); src1_q.delete(); exp_q.delete(); status_q.delete();
    repeat (2) @(negedge PCLK);
    wr_log.delete(); rd_done_log.delete(); rd_setup_log.delete();
    rdy_cnt0 = 0; rdy_cnt1 = 0;
    PRESET = 1'b0;
    @(posedge PCLK); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin
      failures++; $display("FAIL reset_ctl got=%b exp=000", {PSEL, PENABLE, PWRITE});
    end
    checks++;
    if (PADDR !== 4'h0 || PWDATA !== 32'h0) begin
      failures++; $display("FAIL reset_addr_data got=%h/%h exp=0/0", PADDR, PWDATA);
    end
    checks++;
    if ({grant, busy} !== 3'b000) begin
      failures++; $display("FAIL reset_grant_busy got=%b exp=000", {grant, busy});
    end
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      failures++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready});
    end
  endtask

  task automatic test_single();
    int c0;
    wr_rec_t w;
    exp_t e;
    do_reset();
    status_q.push_back(32'h4);
    c0 = cyc;
    src0_q.push_back(8'h5A);
    exp_q.push_back('{1'b0, 8'h5A});
    @(posedge PCLK); #1;
    checks++;
    if (grant !== 2'b01 || busy !== 1'b1) begin
      failures++; $display("FAIL single_grant got=%b busy=%b exp=01 busy=1", grant, busy);
    end
    for (int i = 0; i < 40 && wr_log.size() < 1; i++) begin @(posedge PCLK); #1; end
    checks++;
    if (wr_log.size() != 1) begin
      failures++; $display("FAIL single_timeout got=%0d writes exp=1", wr_log.size());
    end else begin
      w = wr_log.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (w.addr !== 4'h4 || w.wdata !== {24'h0, e.data}) begin
        failures++; $display("FAIL single_write got=%h/%h exp=4/%h", w.addr, w.wdata, {24'h0, e.data});
      end
      checks++;
      if (w.cyc != c0 + 6) begin
        failures++; $display("FAIL single_latency got=%0d exp=%0d", w.cyc - c0, 6);
      end
      checks++;
      if ({w.r1, w.r0} !== 2'b01 || w.gnt !== 2'b01) begin
        failures++; $display("FAIL single_ready got=%b gnt=%b exp=01 gnt=01", {w.r1, w.r0}, w.gnt);
      end
      checks++;
      if (busy !== 1'b0 || grant !== 2'b00) begin
        failures++; $display("FAIL single_idle got=busy %b grant %b exp=0 00", busy, grant);
      end
    end
    repeat (8) @(posedge PCLK); #1;
    checks++;
    if (rdy_cnt0 != 1 || rdy_cnt1 != 0 || rd_done_log.size() != 1) begin
      failures++; $display("FAIL single_counts got=r0 %0d r1 %0d reads %0d exp=1 0 1",
                           rdy_cnt0, rdy_cnt1, rd_done_log.size());
    end
  endtask

  task automatic test_round_robin();
    wr_rec_t w;
    exp_t e;
    int idx;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      src0_q.push_back(8'h10 + 8'(k));
      src1_q.push_back(8'h20 + 8'(k));
    end
    exp_q.push_back('{1'b0, 8'h10}); exp_q.push_back('{1'b0, 8'h11});
    exp_q.push_back('{1'b1, 8'h20}); exp_q.push_back('{1'b1, 8'h21});
    exp_q.push_back('{1'b0, 8'h12}); exp_q.push_back('{1'b0, 8'h13});
    exp_q.push_back('{1'b1, 8'h22}); exp_q.push_back('{1'b1, 8'h23});
    for (int i = 0; i < 100 && wr_log.size() < 8; i++) begin @(posedge PCLK); #1; end
    checks++;
    if (wr_log.size() != 8) begin
      failures++; $display("FAIL rr_timeout got=%0d writes exp=8", wr_log.size());
    end
    idx = 0;
    while (wr_log.size() > 0 && exp_q.size() > 0) begin
      w = wr_log.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (w.addr !== 4'h4 || w.wdata !== {24'h0, e.data}) begin
        failures++; $display("FAIL rr_data idx=%0d got=%h exp=%h", idx, w.wdata, {24'h0, e.data});
      end
      checks++;
      if ({w.r1, w.r0} !== (e.who ? 2'b10 : 2'b01) || w.gnt !== (e.who ? 2'b10 : 2'b01)) begin
        failures++; $display("FAIL rr_owner idx=%0d got=ready %b gnt %b exp=req%0d",
                             idx, {w.r1, w.r0}, w.gnt, e.who);
      end
      idx++;
    end
    repeat (4) @(posedge PCLK); #1;
    checks++;
    if (rdy_cnt0 != 4 || rdy_cnt1 != 4) begin
      failures++; $display("FAIL rr_ready_counts got=%0d/%0d exp=4/4", rdy_cnt0, rdy_cnt1);
    end
  endtask

  task automatic test_full_stall();
    wr_rec_t w;
    do_reset();
    stray = 1'b1;
    status_q.push_back(32'h2); status_q.push_back(32'h2);
    status_q.push_back(32'h2); status_q.push_back(32'h0);
    src1_q.push_back(8'h3C);
    for (int i = 0; i < 100 && wr_log.size() < 1; i++) begin @(posedge PCLK); #1; end
    stray = 1'b0;
    checks++;
    if (wr_log.size() != 1) begin
      failures++; $display("FAIL stall_timeout got=%0d writes exp=1", wr_log.size());
    end else begin
      w = wr_log.pop_front();
      checks++;
      if (w.wdata !== 32'h3C || {w.r1, w.r0} !== 2'b10) begin
        failures++; $display("FAIL stall_write got=%h ready %b exp=3c ready 10", w.wdata, {w.r1, w.r0});
      end
    end
    checks++;
    if (rd_done_log.size() != 4 || rd_setup_log.size() != 4) begin
      failures++; $display("FAIL stall_polls got=%0d reads %0d setups exp=4 4",
                           rd_done_log.size(), rd_setup_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rd_setup_log[i+1] - rd_done_log[i] != POLL_GAP + 1) begin
          failures++; $display("FAIL stall_gap idx=%0d got=%0d exp=%0d",
                               i, rd_setup_log[i+1] - rd_done_log[i], POLL_GAP + 1);
        end
      end
    end
    repeat (8) @(posedge PCLK); #1;
    checks++;
    if (rdy_cnt1 != 1 || rdy_cnt0 != 0 || wr_log.size() != 0) begin
      failures++; $display("FAIL stall_ready_count got=%0d/%0d extra %0d exp=0/1 extra 0",
                           rdy_cnt0, rdy_cnt1, wr_log.size());
    end
  endtask

  task automatic test_reset_mid_write();
    wr_rec_t w;
    bit found;
    do_reset();
    src0_q.push_back(8'h77);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge PCLK); #1;
      if (PSEL && PENABLE && PWRITE && PREADY) begin found = 1'b1; break; end
    end
    checks++;
    if (!found || req0_ready !== 1'b1) begin
      failures++; $display("FAIL rstw_reach got=found %0d ready %b exp=1 1", found, req0_ready);
    end
    PRESET = 1'b1;
    #1;
    checks++;
    if ({PSEL, PENABLE, grant, busy, req0_ready, req1_ready} !== 7'b0) begin
      failures++; $display("FAIL rstw_drop got=%b exp=0000000",
                           {PSEL, PENABLE, grant, busy, req0_ready, req1_ready});
    end
    @(negedge PCLK);
    PRESET = 1'b0;
    for (int i = 0; i < 40 && wr_log.size() < 1; i++) begin @(posedge PCLK); #1; end
    repeat (10) @(posedge PCLK); #1;
    checks++;
    if (wr_log.size() != 1 || rdy_cnt0 != 1) begin
      failures++; $display("FAIL rstw_retry got=%0d writes %0d ready exp=1 1", wr_log.size(), rdy_cnt0);
    end else begin
      w = wr_log.pop_front();
      checks++;
      if (w.wdata !== 32'h77) begin
        failures++; $display("FAIL rstw_data got=%h exp=77", w.wdata);
      end
    end
  endtask

  task automatic test_lone_requester();
    wr_rec_t w;
    exp_t e;
    int prev, idx;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      src1_q.push_back(8'hA0 + 8'(k));
      exp_q.push_back('{1'b1, 8'hA0 + 8'(k)});
    end
    for (int i = 0; i < 120 && wr_log.size() < 10; i++) begin @(posedge PCLK); #1; end
    checks++;
    if (wr_log.size() != 10) begin
      failures++; $display("FAIL lone_timeout got=%0d writes exp=10", wr_log.size());
    end
    prev = -1;
    idx = 0;
    while (wr_log.size() > 0 && exp_q.size() > 0) begin
      w = wr_log.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (w.wdata !== {24'h0, e.data} || {w.r1, w.r0} !== 2'b10) begin
        failures++; $display("FAIL lone_data idx=%0d got=%h ready %b exp=%h ready 10",
                             idx, w.wdata, {w.r1, w.r0}, {24'h0, e.data});
      end
      if (prev >= 0) begin
        checks++;
        if (w.cyc - prev != 7) begin
          failures++; $display("FAIL lone_spacing idx=%0d got=%0d exp=7", idx, w.cyc - prev);
        end
      end
      prev = w.cyc;
      idx++;
    end
    checks++;
    if (bad_rd_addr != 0) begin
      failures++; $display("FAIL read_addr got=%0d non-status reads exp=0", bad_rd_addr);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_reset_mid_write();
    test_lone_requester();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
